// File: rtl/com_fifo_wr_rr_arb.sv
// Round-robin packet arbiter that lets NUM_REQ producers share one sync-FIFO write port.
// Optional statistics counters are enabled with the COM_FIFO_WR_ARB_STAT_EN macro.
module com_fifo_wr_rr_arb #(
    parameter int  NUM_REQ = 4,
    parameter int  DW      = 8,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [NUM_REQ-1:0]    req_vld_i,
    input  logic [NUM_REQ-1:0]    req_last_i,
    input  logic [NUM_REQ*DW-1:0] req_data_i,
    output logic [NUM_REQ-1:0]    req_rdy_o,
    output logic                  fifo_wr_en_o,
    output logic [DW-1:0]         fifo_wr_data_o,
    input  logic                  fifo_wr_full_i,
    output logic [IW-1:0]         grant_id_o,
    output logic                  grant_vld_o
`ifdef COM_FIFO_WR_ARB_STAT_EN
    ,
    output logic [NUM_REQ*16-1:0] stat_pkt_cnt_o,
    output logic [15:0]           stat_stall_cnt_o
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

    state_e               state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        owner_q;

    logic                 flush_s;
    logic                 win_found_s;
    logic [IW-1:0]        win_idx_s;
    logic [IW-1:0]        sel_s;
    logic                 sel_vld_s;
    logic [NUM_REQ-1:0]   req_rdy_s;
    logic                 acc_s;
    logic                 acc_last_s;
    logic [IW-1:0]        next_ptr_s;

    // Round-robin search for the first valid requester starting at rr_ptr.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found_s && req_vld_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                win_found_s = 1'b1;
                win_idx_s   = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Port selection, handshake and FIFO write path (zero-latency pass-through).
    always_comb begin
        flush_s   = rst_i | clear_i;
        req_rdy_s = '0;
        if (state_q == LOCK) begin
            sel_s     = owner_q;
            sel_vld_s = 1'b1;
        end else begin
            sel_s     = win_idx_s;
            sel_vld_s = win_found_s;
        end
        if (sel_vld_s && !fifo_wr_full_i && !flush_s) begin
            req_rdy_s[sel_s] = 1'b1;
        end else begin
            req_rdy_s = '0;
        end
        acc_s      = req_vld_i[sel_s] & req_rdy_s[sel_s];
        acc_last_s = acc_s & req_last_i[sel_s];
        // Explicit wrap so non-power-of-two NUM_REQ returns to 0 after the last index.
        if (int'(sel_s) == NUM_REQ - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = sel_s + IW'(1);
        end
        if (acc_s) begin
            fifo_wr_data_o = req_data_i[int'(sel_s)*DW +: DW];
        end else begin
            fifo_wr_data_o = '0;
        end
        if (sel_vld_s && !flush_s) begin
            grant_id_o = sel_s;
        end else begin
            grant_id_o = '0;
        end
        req_rdy_o    = req_rdy_s;
        fifo_wr_en_o = acc_s;
        grant_vld_o  = (state_q == LOCK) && !flush_s;
    end

    // Arbitration FSM: a packet locks the port from its first accepted beat to its last.
    always_ff @(posedge clk_i) begin
        if (flush_s) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc_last_s) begin
                        rr_ptr_q <= next_ptr_s;
                    end else if (acc_s) begin
                        state_q <= LOCK;
                        owner_q <= sel_s;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOCK: begin
                    if (acc_last_s) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr_s;
                    end else begin
                        state_q <= LOCK;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef COM_FIFO_WR_ARB_STAT_EN
    logic [NUM_REQ*16-1:0] pkt_cnt_q;
    logic [15:0]           stall_cnt_q;

    // Saturating packet and stall counters.
    always_ff @(posedge clk_i) begin
        if (flush_s) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= 16'h0000;
        end else begin
            if (acc_last_s && (pkt_cnt_q[int'(sel_s)*16 +: 16] != 16'hFFFF)) begin
                pkt_cnt_q[int'(sel_s)*16 +: 16] <= pkt_cnt_q[int'(sel_s)*16 +: 16] + 16'd1;
            end else begin
                pkt_cnt_q <= pkt_cnt_q;
            end
            if ((|req_vld_i) && fifo_wr_full_i && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign stat_pkt_cnt_o   = pkt_cnt_q;
    assign stat_stall_cnt_o = stall_cnt_q;
`endif

endmodule
